// File: rtl/l2arb_pkg.sv
// Shared types and constants for the L2 refill arbiter.
// L2ARB_RR_EN (see rr_arb2) selects round-robin versus fixed-priority grant.
package l2arb_pkg;
  localparam int LINE_WORDS = 8;
  localparam int WORD_W     = 32;
  localparam int ADDR_W     = 64;
  localparam int OFFSET_W   = 5;
  localparam int CNT_W      = $clog2(LINE_WORDS);
  localparam int NUM_REQ    = 2;

  typedef logic [LINE_WORDS-1:0][WORD_W-1:0] line_t;

  typedef enum logic [1:0] {IDLE, AR, R, RESP} state_e;
  typedef enum logic {REQ_I = 1'b0, REQ_D = 1'b1} req_id_e;

  typedef struct packed {
    logic              pend;
    logic [ADDR_W-1:0] addr;
  } req_slot_t;

  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// Two-requester grant select. L2ARB_RR_EN: round-robin with a last-grant register;
// otherwise fixed priority with the dcache winning ties.
module rr_arb2
  import l2arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_take,
  output req_id_e    o_gnt_id
);
`ifdef L2ARB_RR_EN
  req_id_e r_last;

  always_comb begin
    o_gnt_id = REQ_I;
    if (&i_req)            o_gnt_id = (r_last == REQ_D) ? REQ_I : REQ_D;
    else if (i_req[REQ_D]) o_gnt_id = REQ_D;
  end

  // Pointer only moves on contested grants, so a lone request never steals the next tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   r_last <= REQ_D;
    else if (i_take && (&i_req))  r_last <= o_gnt_id;
  end
`else
  logic w_unused;
  assign w_unused = clk ^ rst_n ^ i_take ^ i_req[REQ_I];
  assign o_gnt_id = i_req[REQ_D] ? REQ_D : REQ_I;
`endif
endmodule

// File: rtl/l2_refill_arb.sv
// Shares one L2 read port between icache and dcache refills: latch, arbitrate,
// issue an 8-beat burst, assemble the line and pulse rask to the owner.
module l2_refill_arb
  import l2arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              icache_l2_rreq,
  input  logic [ADDR_W-1:0] icache_l2_raddr,
  output line_t             l2_icache_rdata,
  output logic              l2_icache_rask,
  input  logic              dcache_l2_rreq,
  input  logic [ADDR_W-1:0] dcache_l2_raddr,
  output line_t             l2_dcache_rdata,
  output logic              l2_dcache_rask,
  output logic              mem_arvalid,
  output logic [ADDR_W-1:0] mem_araddr,
  output logic [7:0]        mem_arlen,
  input  logic              mem_arready,
  input  logic              mem_rvalid,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_rlast,
  output logic              mem_rready,
  output logic              arb_err
);
  state_e                          r_state;
  req_id_e                         r_owner;
  req_id_e                         w_gnt_id;
  logic [NUM_REQ-1:0]              w_pulse, w_acc, w_clr, w_cand, r_rask;
  logic [NUM_REQ-1:0][ADDR_W-1:0]  w_raddr, w_cand_addr;
  line_t                           r_line;
  logic [CNT_W-1:0]                r_cnt;
  logic                            r_arvalid, r_rready, r_err;
  logic [ADDR_W-1:0]               r_araddr;
  logic                            w_grant_ok, w_beat, w_last;

  assign w_pulse = {dcache_l2_rreq, icache_l2_rreq};
  assign w_raddr = {dcache_l2_raddr, icache_l2_raddr};

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    req_slot_t r_slot;
    logic      w_own;

    assign w_own          = (r_owner == req_id_e'(g));
    assign w_acc[g]       = w_pulse[g] & ~r_slot.pend;
    assign w_clr[g]       = (r_state == RESP) & w_own;
    // A fresh pulse is grantable in the same cycle it arrives.
    assign w_cand[g]      = (r_slot.pend & ~w_clr[g]) | w_acc[g];
    assign w_cand_addr[g] = r_slot.pend ? r_slot.addr : w_raddr[g];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_slot <= '0;
      end else if (w_acc[g]) begin
        r_slot.pend <= 1'b1;
        r_slot.addr <= w_raddr[g];
      end else if (w_clr[g]) begin
        r_slot.pend <= 1'b0;
      end
    end
  end

  // RESP doubles as an idle slot so the next burst's arvalid follows rask directly.
  assign w_grant_ok = ((r_state == IDLE) || (r_state == RESP)) && (|w_cand);
  assign w_beat     = r_rready & mem_rvalid;
  assign w_last     = (r_cnt == CNT_W'(LINE_WORDS-1));

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    (w_cand),
    .i_take   (w_grant_ok),
    .o_gnt_id (w_gnt_id)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_owner   <= REQ_I;
      r_arvalid <= 1'b0;
      r_araddr  <= '0;
      r_rready  <= 1'b0;
      r_rask    <= '0;
      r_cnt     <= '0;
    end else begin
      r_rask <= '0;
      unique case (r_state)
        IDLE, RESP: begin
          if (w_grant_ok) begin
            r_state   <= AR;
            r_owner   <= w_gnt_id;
            r_arvalid <= 1'b1;
            r_araddr  <= line_align(w_cand_addr[w_gnt_id]);
          end else begin
            r_state <= IDLE;
          end
        end
        AR: begin
          if (mem_arready) begin
            r_state   <= R;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_cnt     <= '0;
          end
        end
        R: begin
          if (mem_rvalid) begin
            r_cnt <= r_cnt + CNT_W'(1);
            // Completion follows the beat count; rlast is only cross-checked.
            if (w_last) begin
              r_state         <= RESP;
              r_rready        <= 1'b0;
              r_rask[r_owner] <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line <= '0;
      r_err  <= 1'b0;
    end else if (w_beat) begin
      r_line[r_cnt] <= mem_rdata;
      if (mem_rlast != w_last) r_err <= 1'b1;
    end
  end

  assign mem_arvalid     = r_arvalid;
  assign mem_araddr      = r_araddr;
  assign mem_arlen       = 8'(LINE_WORDS-1);
  assign mem_rready      = r_rready;
  assign l2_icache_rask  = r_rask[REQ_I];
  assign l2_dcache_rask  = r_rask[REQ_D];
  assign l2_icache_rdata = r_line;
  assign l2_dcache_rdata = r_line;
  assign arb_err         = r_err;
endmodule
